// File: rtl/bcd_count_ctrl.sv
// Command-driven controller for a cascaded mod-MODULUS digit counter chain.
// Counts enabled ticks up to a programmable terminal count, then holds a done event until acknowledged.
module bcd_count_ctrl #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_data,
  input  logic                tick_en,
  output logic [4*DIGITS-1:0] q,
  output logic                busy,
  output logic                done_valid,
  input  logic                done_ready
);

  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] DMAX = 4'(MODULUS - 1);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   term, term_nxt, q_nxt, q_inc, load_val;
  logic           accept;

  // Command handshake: a command transfers on any edge where cmd_valid and
  // cmd_ready are both high; cmd_op/cmd_data are only looked at on that edge.
  assign cmd_ready  = (state != S_DONE);
  assign busy       = (state == S_RUN) || (state == S_PAUSE);
  assign done_valid = (state == S_DONE);
  assign accept     = cmd_valid && cmd_ready;

  // Ripple-carry increment across the digit chain, each digit wrapping at DMAX.
  always_comb begin
    logic carry;
    q_inc = q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == DMAX) begin
          q_inc[4*i +: 4] = 4'd0;
        end else begin
          q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  // Illegal digits in a loaded terminal count saturate to the top digit value.
  always_comb begin
    load_val = cmd_data;
    for (int i = 0; i < DIGITS; i++) begin
      if (cmd_data[4*i +: 4] > DMAX) load_val[4*i +: 4] = DMAX;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    term_nxt  = term;
    case (state)
      S_IDLE, S_PAUSE: begin
        if (accept) begin
          case (cmd_op)
            OP_START: state_nxt = (q == term) ? S_DONE : S_RUN;
            OP_LOAD:  term_nxt  = load_val;
            OP_CLEAR: begin
              state_nxt = S_IDLE;
              q_nxt     = '0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // STOP and CLEAR pre-empt a coincident tick; START and LOAD do not.
        if (accept && cmd_op == OP_STOP) begin
          state_nxt = S_PAUSE;
        end else if (accept && cmd_op == OP_CLEAR) begin
          state_nxt = S_IDLE;
          q_nxt     = '0;
        end else if (tick_en) begin
          q_nxt = q_inc;
          if (q_inc == term) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          state_nxt = S_IDLE;
          q_nxt     = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      q     <= '0;
      term  <= {DIGITS{DMAX}};
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      term  <= term_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed plus randomized bench for bcd_count_ctrl against an integer-count reference model.
module tb_bcd_count_ctrl;

  localparam int DIGITS  = 2;
  localparam int MODULUS = 10;
  localparam int W       = 4 * DIGITS;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         tick_en;
  logic [W-1:0] q;
  logic         busy;
  logic         done_valid;
  logic         done_ready;

  int n_cmp = 0;
  int n_err = 0;

  int m_state;
  int m_cnt;
  int m_term;

  bcd_count_ctrl #(.DIGITS(DIGITS), .MODULUS(MODULUS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .tick_en    (tick_en),
    .q          (q),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ready (done_ready)
  );

  always #5 clk = ~clk;

  function automatic int pw(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * MODULUS;
    return r;
  endfunction

  function automatic logic [W-1:0] to_digits(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pw(i)) % MODULUS);
    return r;
  endfunction

  // Interpret a LOAD word as an integer, saturating out-of-range digits.
  function automatic int load_value(input logic [W-1:0] d);
    int v = 0;
    int dig;
    for (int i = 0; i < DIGITS; i++) begin
      dig = int'(d[4*i +: 4]);
      if (dig > MODULUS - 1) dig = MODULUS - 1;
      v = v + dig * pw(i);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_term  = pw(DIGITS) - 1;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                            input logic t, input logic dr);
    logic acc;
    acc = v && (m_state != M_DONE);
    if (m_state == M_DONE) begin
      if (dr) begin
        m_state = M_IDLE;
        m_cnt   = 0;
      end
    end else if (acc && op == OP_CLEAR) begin
      m_state = M_IDLE;
      m_cnt   = 0;
    end else if (m_state == M_RUN) begin
      if (acc && op == OP_STOP) m_state = M_PAUSE;
      else if (t) begin
        m_cnt = (m_cnt + 1) % pw(DIGITS);
        if (m_cnt == m_term) m_state = M_DONE;
      end
    end else if (acc && op == OP_START) begin
      m_state = (m_cnt == m_term) ? M_DONE : M_RUN;
    end else if (acc && op == OP_LOAD) begin
      m_term = load_value(d);
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, q, to_digits(m_cnt));
    check({tag, ".busy"}, W'(busy), W'(m_state == M_RUN || m_state == M_PAUSE));
    check({tag, ".done_valid"}, W'(done_valid), W'(m_state == M_DONE));
    check({tag, ".cmd_ready"}, W'(cmd_ready), W'(m_state != M_DONE));
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [W-1:0] d, input logic t, input logic dr);
    @(negedge clk);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_data   = d;
    tick_en    = t;
    done_ready = dr;
    model_edge(v, op, d, t, dr);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic cmd(input string tag, input logic [1:0] op, input logic [W-1:0] d);
    step(tag, 1'b1, op, d, 1'b0, 1'b0);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, OP_START, '0, 1'b1, 1'b0);
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic dr);
    for (int i = 0; i < n; i++) step(tag, 1'b0, OP_START, '0, 1'b0, dr);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = OP_START;
    cmd_data   = '0;
    tick_en    = 1'b0;
    done_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Count to 25 and check the done event.
    cmd("load25", OP_LOAD, 8'h25);
    cmd("start25", OP_START, '0);
    ticks("count25", 25);
    check("q_at_25", q, 8'h25);
    check("done_at_25", W'(done_valid), W'(1));

    // Hold off the acknowledge, then take it.
    idle_cycles("done_hold", 5, 1'b0);
    idle_cycles("done_ack", 1, 1'b1);
    check("q_after_ack", q, 8'h00);

    // Pause and resume around a coincident STOP+tick.
    cmd("start_p", OP_START, '0);
    ticks("run7", 7);
    step("stop_tick", 1'b1, OP_STOP, '0, 1'b1, 1'b0);
    check("q_frozen", q, 8'h07);
    ticks("paused", 3);
    cmd("resume", OP_START, '0);
    ticks("resumed", 3);
    check("q_resumed", q, 8'h10);
    cmd("clear", OP_CLEAR, '0);

    // Illegal digits saturate to 99.
    cmd("load_af", OP_LOAD, 8'hAF);
    cmd("start99", OP_START, '0);
    ticks("count99", 99);
    check("q_at_99", q, 8'h99);
    idle_cycles("ack99", 1, 1'b1);

    // Zero terminal count completes immediately.
    cmd("load00", OP_LOAD, 8'h00);
    cmd("start00", OP_START, '0);
    check("done_at_0", W'(done_valid), W'(1));
    idle_cycles("ack00", 1, 1'b1);

    // LOAD during RUN is ignored while a coincident tick still counts.
    cmd("load30", OP_LOAD, 8'h30);
    cmd("start30", OP_START, '0);
    ticks("run30a", 4);
    step("load_in_run", 1'b1, OP_LOAD, 8'h05, 1'b1, 1'b0);
    ticks("run30b", 25);
    check("q_at_30", q, 8'h30);
    idle_cycles("ack30", 1, 1'b1);

    // Asynchronous reset between edges in mid-count.
    cmd("start_r", OP_START, '0);
    ticks("run13", 13);
    check("q_at_13", q, 8'h13);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ticks("no_start", 3);
    cmd("start_after_rst", OP_START, '0);
    ticks("after_rst", 4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
